// File: rtl/gactx_drain_pkg.sv
// Shared constants for the GACTX direction drain: state encodings, header layout.
// Field positions are bit offsets within each 64-bit header beat.
package gactx_drain_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HDR      = 3'd1;
  localparam logic [2:0] ST_RD       = 3'd2;
  localparam logic [2:0] ST_FLUSH    = 3'd3;
  localparam logic [2:0] ST_CLR      = 3'd5;
  localparam logic [2:0] ST_WAIT_CLR = 3'd6;
`ifdef GACTX_DRAIN_CKSUM_EN
  localparam logic [2:0] ST_CKSUM    = 3'd4;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_HDR      = ST_HDR,
    S_RD       = ST_RD,
    S_FLUSH    = ST_FLUSH,
    S_CLR      = ST_CLR,
    S_WAIT_CLR = ST_WAIT_CLR
`ifdef GACTX_DRAIN_CKSUM_EN
    , S_CKSUM  = ST_CKSUM
`endif
  } state_t;

  localparam int HDR_WORDS = 3;
  localparam int FIELD_W   = 16;
  localparam int HALF_W    = 32;

  localparam int H0_SCORE_LSB = 32;
  localparam int H0_STEPS_LSB = 0;
  localparam int H1_REF_LSB   = 48;
  localparam int H1_QRY_LSB   = 32;
  localparam int H1_NREF_LSB  = 16;
  localparam int H1_NQRY_LSB  = 0;
  localparam int H2_COUNT_LSB = 32;

endpackage

// File: rtl/gactx_drain_fifo.sv
// Generic synchronous FIFO, DEPTH x WIDTH, show-ahead read; push on full is accepted
// only together with a pop, so occupancy is unchanged in that case.
module gactx_drain_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = push && (!full || pop);
  assign rd_en   = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gactx_dir_drain.sv
// Drains one GACTX tile: 3 header beats, then every direction BRAM word, then clear_done.
// First beat valid 1 cycle after done; reads are credit-limited by FIFO space (GACTX_DRAIN_CKSUM_EN adds an XOR beat).
module gactx_dir_drain
  import gactx_drain_pkg::*;
#(
  parameter int PE_WIDTH            = 25,
  parameter int LOG_MAX_TILE_SIZE   = 11,
  parameter int NUM_DIR_BLOCK       = 32,
  parameter int DIR_BRAM_ADDR_WIDTH = 14,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             done,
  output logic                             clear_done,
  input  logic [PE_WIDTH-1:0]              tile_score,
  input  logic [LOG_MAX_TILE_SIZE-1:0]     ref_max_pos,
  input  logic [LOG_MAX_TILE_SIZE-1:0]     query_max_pos,
  input  logic [2*LOG_MAX_TILE_SIZE-1:0]   num_tb_steps,
  input  logic [LOG_MAX_TILE_SIZE-1:0]     num_ref_bases,
  input  logic [LOG_MAX_TILE_SIZE-1:0]     num_query_bases,
  input  logic [DIR_BRAM_ADDR_WIDTH-1:0]   dir_total_count,
  output logic [DIR_BRAM_ADDR_WIDTH-1:0]   dir_rd_addr,
  input  logic [2*NUM_DIR_BLOCK-1:0]       dir_data_out,
  output logic [2*NUM_DIR_BLOCK-1:0]       out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             busy
);

  localparam int AW    = DIR_BRAM_ADDR_WIDTH;
  localparam int LW    = LOG_MAX_TILE_SIZE;
  localparam int DW    = 2 * NUM_DIR_BLOCK;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
`ifdef GACTX_DRAIN_CKSUM_EN
  localparam bit CKSUM_EN = 1'b1;
`else
  localparam bit CKSUM_EN = 1'b0;
`endif

  state_t            state, state_nxt;
  logic [LW-1:0]     ref_q, qry_q, nref_q, nqry_q;
  logic [AW-1:0]     total_q;
  logic [AW-1:0]     addr_q;
  logic [1:0]        hdr_idx;
  logic              in_flight;
  logic              in_flight_last;

  logic              latch;
  logic              issue;
  logic              last_addr;
  logic              room;
  logic              push_ok;
  logic [CNT_W:0]    occ;
  logic [DW-1:0]     h0, h1, h2;

  logic              fifo_push;
  logic [DW:0]       fifo_wdat;
  logic              fifo_pop;
  logic [DW:0]       fifo_rdat;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

`ifdef GACTX_DRAIN_CKSUM_EN
  logic [DW-1:0]     cksum_q;
  logic              cks_pushed;
  logic              cks_push;
`endif

  gactx_drain_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (fifo_wdat),
    .pop      (fifo_pop),
    .pop_dat  (fifo_rdat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign out_valid   = !fifo_empty;
  assign out_data    = out_valid ? fifo_rdat[DW-1:0] : '0;
  assign out_last    = out_valid && fifo_rdat[DW];
  assign fifo_pop    = out_valid && out_ready;
  assign busy        = (state != S_IDLE);
  assign dir_rd_addr = addr_q;

  // Outstanding BRAM reads count against FIFO space so returning data always fits.
  assign occ       = {1'b0, fifo_count} + {{CNT_W{1'b0}}, in_flight};
  assign room      = (occ < DEPTH_C);
  assign push_ok   = !fifo_full || fifo_pop;
  assign last_addr = (addr_q == total_q - AW'(1));

  // H0 is built straight from the inputs so it can be pushed in the cycle done is seen.
  always_comb begin
    h0 = '0;
    h0[H0_SCORE_LSB +: HALF_W] = HALF_W'($signed(tile_score));
    h0[H0_STEPS_LSB +: HALF_W] = HALF_W'(num_tb_steps);
    h1 = '0;
    h1[H1_REF_LSB  +: FIELD_W] = FIELD_W'(ref_q);
    h1[H1_QRY_LSB  +: FIELD_W] = FIELD_W'(qry_q);
    h1[H1_NREF_LSB +: FIELD_W] = FIELD_W'(nref_q);
    h1[H1_NQRY_LSB +: FIELD_W] = FIELD_W'(nqry_q);
    h2 = '0;
    h2[H2_COUNT_LSB +: HALF_W] = HALF_W'(total_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fifo_push  = 1'b0;
    fifo_wdat  = '0;
    issue      = 1'b0;
    latch      = 1'b0;
    clear_done = 1'b0;
`ifdef GACTX_DRAIN_CKSUM_EN
    cks_push   = 1'b0;
`endif
    if (in_flight) begin
      fifo_push = 1'b1;
      fifo_wdat = {in_flight_last, dir_data_out};
    end
    case (state)
      S_IDLE: begin
        if (done) begin
          latch     = 1'b1;
          fifo_push = 1'b1;
          fifo_wdat = {1'b0, h0};
          state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (push_ok) begin
          fifo_push = 1'b1;
          if (hdr_idx == 2'(HDR_WORDS - 1)) begin
            fifo_wdat = {(total_q == '0) && !CKSUM_EN, h2};
            state_nxt = (total_q == '0) ? S_FLUSH : S_RD;
          end else begin
            fifo_wdat = {1'b0, h1};
          end
        end
      end
      S_RD: begin
        if (room) begin
          issue = 1'b1;
          if (last_addr) state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
`ifdef GACTX_DRAIN_CKSUM_EN
        if (!in_flight) state_nxt = S_CKSUM;
`else
        if (!in_flight && fifo_empty) state_nxt = S_CLR;
`endif
      end
`ifdef GACTX_DRAIN_CKSUM_EN
      S_CKSUM: begin
        if (!cks_pushed) begin
          if (push_ok) begin
            cks_push  = 1'b1;
            fifo_push = 1'b1;
            fifo_wdat = {1'b1, cksum_q};
          end
        end else if (fifo_empty) begin
          state_nxt = S_CLR;
        end
      end
`endif
      S_CLR: begin
        clear_done = 1'b1;
        state_nxt  = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        // done is only watched for its fall here; a held level cannot restart the tile.
        if (!done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_q          <= '0;
      qry_q          <= '0;
      nref_q         <= '0;
      nqry_q         <= '0;
      total_q        <= '0;
      addr_q         <= '0;
      hdr_idx        <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      in_flight      <= issue;
      in_flight_last <= issue && last_addr && !CKSUM_EN;
      if (latch) begin
        ref_q   <= ref_max_pos;
        qry_q   <= query_max_pos;
        nref_q  <= num_ref_bases;
        nqry_q  <= num_query_bases;
        total_q <= dir_total_count;
        hdr_idx <= 2'd1;
        addr_q  <= '0;
      end else begin
        if (state == S_HDR && fifo_push) hdr_idx <= hdr_idx + 2'd1;
        if (issue) addr_q <= addr_q + AW'(1);
      end
    end
  end

`ifdef GACTX_DRAIN_CKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cksum_q    <= '0;
      cks_pushed <= 1'b0;
    end else if (state == S_IDLE) begin
      cksum_q    <= '0;
      cks_pushed <= 1'b0;
    end else begin
      if (in_flight) cksum_q <= cksum_q ^ dir_data_out;
      if (cks_push) cks_pushed <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gactx_dir_drain.sv
// Bench for gactx_dir_drain: table of tiles checked through an expected-beat queue,
// plus hand sequences for held done, back-to-back throughput and mid-tile reset.
module tb_gactx_dir_drain;

`ifdef GACTX_DRAIN_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  typedef struct {
    logic [24:0] score;
    logic [21:0] steps;
    logic [10:0] rp, qp, nr, nq;
    logic [13:0] cnt;
    bit          rnd;
    logic [63:0] h0, h1, h2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        done = 1'b0;
  logic        clear_done;
  logic [24:0] tile_score = '0;
  logic [10:0] ref_max_pos = '0, query_max_pos = '0, num_ref_bases = '0, num_query_bases = '0;
  logic [21:0] num_tb_steps = '0;
  logic [13:0] dir_total_count = '0;
  logic [13:0] dir_rd_addr;
  logic [63:0] dir_data_out = '0;
  logic [63:0] out_data;
  logic        out_valid, out_last, busy;
  logic        out_ready = 1'b1;

  int          checks = 0, errors = 0, cyc = 0, cur_tile = 0;
  int          beat_n = 0, clr_cnt = 0, tile_base = 0, clr_base = 0;
  bit          ready_rand = 1'b0;
  int          beat_cyc[$];
  logic [13:0] max_addr = '0;
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  bit          stall = 1'b0;
  logic [63:0] st_data = '0;
  logic        st_last = 1'b0;
  vec_t        vt[5];

  gactx_dir_drain dut (
    .clk (clk), .rst (rst), .done (done), .clear_done (clear_done),
    .tile_score (tile_score), .ref_max_pos (ref_max_pos), .query_max_pos (query_max_pos),
    .num_tb_steps (num_tb_steps), .num_ref_bases (num_ref_bases),
    .num_query_bases (num_query_bases), .dir_total_count (dir_total_count),
    .dir_rd_addr (dir_rd_addr), .dir_data_out (dir_data_out),
    .out_data (out_data), .out_valid (out_valid), .out_ready (out_ready),
    .out_last (out_last), .busy (busy)
  );

  function automatic logic [63:0] bram_word(input int t, input int a);
    logic [31:0] lo;
    lo = 32'(a) * 32'h9E3779B9;
    lo = lo ^ 32'(t);
    return {t[7:0], a[23:0], lo};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) dir_data_out <= bram_word(cur_tile, int'(dir_rd_addr));
  always @(posedge clk) begin
    #1;
    out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("stall_valid", {63'b0, out_valid}, 64'd1);
        check("stall_data", out_data, st_data);
        check("stall_last", {63'b0, out_last}, {63'b0, st_last});
      end
      if (clear_done) clr_cnt++;
      if (!busy) max_addr = '0;
      else if (dir_rd_addr > max_addr) max_addr = dir_rd_addr;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected no beat", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", out_data, mon_e[63:0]);
          check("beat_last", {63'b0, out_last}, {63'b0, mon_e[64]});
        end
        beat_cyc.push_back(cyc);
        beat_n++;
      end
      stall   = out_valid && !out_ready;
      st_data = out_data;
      st_last = out_last;
    end
  end

  task automatic push_exp(input vec_t v, input int t);
    logic [63:0] x;
    logic [63:0] w;
    x = '0;
    exp_q.push_back({1'b0, v.h0});
    exp_q.push_back({1'b0, v.h1});
    exp_q.push_back({(v.cnt == 0) && (CK == 0), v.h2});
    for (int i = 0; i < int'(v.cnt); i++) begin
      w = bram_word(t, i);
      x = x ^ w;
      exp_q.push_back({(i == int'(v.cnt) - 1) && (CK == 0), w});
    end
    if (CK != 0) exp_q.push_back({1'b1, x});
  endtask

  task automatic drive_tile(input vec_t v, input int t);
    cur_tile        = t;
    ready_rand      = v.rnd;
    tile_score      = v.score;
    num_tb_steps    = v.steps;
    ref_max_pos     = v.rp;
    query_max_pos   = v.qp;
    num_ref_bases   = v.nr;
    num_query_bases = v.nq;
    dir_total_count = v.cnt;
    push_exp(v, t);
    tile_base = beat_n;
    clr_base  = clr_cnt;
    @(posedge clk);
    #1;
    done = 1'b1;
  endtask

  task automatic run_tile(input vec_t v, input int t, input int hold);
    bit seen;
    seen = 1'b0;
    drive_tile(v, t);
    @(negedge clk);
    check("valid_before_done_seen", {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    check("h0_valid_next_cycle", {63'b0, out_valid}, 64'd1);
    check("h0_data_next_cycle", out_data, v.h0);
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk);
      if (clear_done) seen = 1'b1;
    end
    check("clear_done_seen", {63'b0, seen}, 64'd1);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("busy_while_done_held", {63'b0, busy}, 64'd1);
    end
    @(posedge clk);
    #1;
    done = 1'b0;
    ready_rand = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_done_low", {63'b0, busy}, 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("beat_count", 64'(beat_n - tile_base), 64'(3 + int'(v.cnt) + CK));
    check("clear_done_pulses", 64'(clr_cnt - clr_base), 64'd1);
    check("reads_issued", 64'(max_addr), 64'(v.cnt));
  endtask

  initial begin
    vt[0] = '{25'h1FFFFFB, 22'd300, 11'd100, 11'd90, 11'd120, 11'd110, 14'd3, 1'b0,
              64'hFFFFFFFB_0000012C, 64'h0064_005A_0078_006E, 64'h00000003_00000000};
    vt[1] = '{25'd7, 22'd0, 11'd0, 11'd0, 11'd0, 11'd0, 14'd0, 1'b0,
              64'h00000007_00000000, 64'h0000_0000_0000_0000, 64'h00000000_00000000};
    vt[2] = '{25'd1000, 22'd5000, 11'd2047, 11'd1, 11'd2000, 11'd3, 14'd100, 1'b1,
              64'h000003E8_00001388, 64'h07FF_0001_07D0_0003, 64'h00000064_00000000};
    vt[3] = '{25'h1000000, 22'h3FFFFF, 11'd5, 11'd6, 11'd7, 11'd8, 14'd100, 1'b0,
              64'hFF000000_003FFFFF, 64'h0005_0006_0007_0008, 64'h00000064_00000000};
    vt[4] = '{25'd1, 22'd2, 11'd1, 11'd2, 11'd3, 11'd4, 14'd2, 1'b1,
              64'h00000001_00000002, 64'h0001_0002_0003_0004, 64'h00000002_00000000};

    #12;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_last", {63'b0, out_last}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_clear_done", {63'b0, clear_done}, 64'd0);
    check("rst_dir_rd_addr", 64'(dir_rd_addr), 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      run_tile(vt[i], i + 1, (i == 0) ? 3 : 0);
      if (i == 3) begin
        for (int b = 4; b <= 102; b++)
          check("dir_beats_back_to_back",
                64'(beat_cyc[tile_base + b] - beat_cyc[tile_base + b - 1]), 64'd1);
      end
    end

    // Reset in the middle of the direction reads must abort the tile without clear_done.
    drive_tile(vt[3], 9);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_out_last", {63'b0, out_last}, 64'd0);
    check("midrst_out_data", out_data, 64'd0);
    check("midrst_dir_rd_addr", 64'(dir_rd_addr), 64'd0);
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_clear_done", {63'b0, clear_done}, 64'd0);
    exp_q.delete();
    done = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_clear_done", 64'(clr_cnt - clr_base), 64'd0);
    check("midrst_idle_after_release", {63'b0, busy}, 64'd0);
    run_tile(vt[0], 10, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
